// File: rtl/alu32_ff.sv
// rtl/alu32_ff.sv - 32-bit RV32IM execute-stage ALU with registered result
//
// Purpose:
//   Single-cycle integer ALU covering the RV32I arithmetic/logic/shift ops,
//   the RV32M multiply/divide ops and the branch compares. Every operation,
//   multiply and divide included, is computed combinationally from ctl/op1/op2.
//   The result is captured into res on every rising clock edge, so the latency
//   is one cycle and the throughput is one operation per cycle.
//
// Ports:
//   clk  in   1   rising-edge clock
//   rst  in   1   synchronous active-high reset; forces res to 0
//   ctl  in  24   one-hot operation select:
//                 0 ADD  1 SUB  2 AND  3 OR  4 XOR  5 SLL  6 SRL  7 SRA
//                 8 SLT  9 SLTU 10 MUL 11 MULH 12 MULHSU 13 MULHU
//                 14 DIV 15 DIVU 16 REM 17 REMU
//                 18 EQ  19 NE  20 LT  21 GE  22 LTU  23 GEU
//                 An all-zero or multi-bit ctl produces res = 0.
//   op1  in  32   operand 1 (rs1)
//   op2  in  32   operand 2 (rs2 / immediate)
//   res  out 32   registered result

module alu32_ff (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] ctl,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res
);

    localparam int OP_ADD    = 0;
    localparam int OP_SUB    = 1;
    localparam int OP_AND    = 2;
    localparam int OP_OR     = 3;
    localparam int OP_XOR    = 4;
    localparam int OP_SLL    = 5;
    localparam int OP_SRL    = 6;
    localparam int OP_SRA    = 7;
    localparam int OP_SLT    = 8;
    localparam int OP_SLTU   = 9;
    localparam int OP_MUL    = 10;
    localparam int OP_MULH   = 11;
    localparam int OP_MULHSU = 12;
    localparam int OP_MULHU  = 13;
    localparam int OP_DIV    = 14;
    localparam int OP_DIVU   = 15;
    localparam int OP_REM    = 16;
    localparam int OP_REMU   = 17;
    localparam int OP_EQ     = 18;
    localparam int OP_NE     = 19;
    localparam int OP_LT     = 20;
    localparam int OP_GE     = 21;
    localparam int OP_LTU    = 22;
    localparam int OP_GEU    = 23;

    // ------------------------------------------------------------------
    // Control decode: exactly one bit must be set for a defined operation.
    // ------------------------------------------------------------------
    logic        ctl_onehot;
    assign ctl_onehot = (ctl != '0) && ((ctl & (ctl - 24'd1)) == '0);

    // ------------------------------------------------------------------
    // Add / subtract / logic / shifts
    // ------------------------------------------------------------------
    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;

    assign shamt   = op2[4:0];
    assign sum     = op1 + op2;
    assign diff    = op1 - op2;
    assign sll_res = op1 << shamt;
    assign srl_res = op1 >> shamt;
    assign sra_res = $signed(op1) >>> shamt;

    // ------------------------------------------------------------------
    // Compares
    // ------------------------------------------------------------------
    logic lt_s;
    logic lt_u;
    logic eq;

    assign lt_s = $signed(op1) < $signed(op2);
    assign lt_u = op1 < op2;
    assign eq   = op1 == op2;

    // ------------------------------------------------------------------
    // Multiply
    // A single unsigned 32x32 product serves all four multiply ops. The
    // signed high halves follow from the identity
    //   hi_signed(a) = hi_unsigned(a) - (a<0 ? b : 0)
    // applied to each signed operand, all modulo 2^32.
    // ------------------------------------------------------------------
    logic [63:0] prod_uu;
    logic [31:0] corr_op1_neg;
    logic [31:0] corr_op2_neg;
    logic [31:0] mulhu_res;
    logic [31:0] mulhsu_res;
    logic [31:0] mulh_res;

    assign prod_uu      = {32'd0, op1} * {32'd0, op2};
    assign corr_op1_neg = op1[31] ? op2 : 32'd0;
    assign corr_op2_neg = op2[31] ? op1 : 32'd0;
    assign mulhu_res    = prod_uu[63:32];
    assign mulhsu_res   = prod_uu[63:32] - corr_op1_neg;
    assign mulh_res     = prod_uu[63:32] - corr_op1_neg - corr_op2_neg;

    // ------------------------------------------------------------------
    // Divide
    // Signed division works on magnitudes and fixes signs afterwards:
    // quotient is negative when the operand signs differ, remainder takes
    // the dividend's sign. The overflow case 0x80000000 / -1 falls out
    // naturally (magnitude 0x80000000 negates to itself, remainder 0).
    // A zero divisor is replaced by 1 so the dividers never see zero; the
    // architected zero-divide results are substituted below.
    // ------------------------------------------------------------------
    logic        div_zero;
    logic [31:0] divisor_u;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [31:0] mag2_safe;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    assign div_zero  = op2 == 32'd0;
    assign divisor_u = div_zero ? 32'd1 : op2;
    assign quot_u    = op1 / divisor_u;
    assign rem_u     = op1 % divisor_u;

    assign mag1      = op1[31] ? (~op1 + 32'd1) : op1;
    assign mag2      = op2[31] ? (~op2 + 32'd1) : op2;
    assign mag2_safe = div_zero ? 32'd1 : mag2;
    assign quot_mag  = mag1 / mag2_safe;
    assign rem_mag   = mag1 % mag2_safe;
    assign quot_s    = (op1[31] ^ op2[31]) ? (~quot_mag + 32'd1) : quot_mag;
    assign rem_s     = op1[31] ? (~rem_mag + 32'd1) : rem_mag;

    // ------------------------------------------------------------------
    // Per-operation result table
    // ------------------------------------------------------------------
    logic [31:0] op_res [24];

    always_comb begin
        op_res[OP_ADD]    = sum;
        op_res[OP_SUB]    = diff;
        op_res[OP_AND]    = op1 & op2;
        op_res[OP_OR]     = op1 | op2;
        op_res[OP_XOR]    = op1 ^ op2;
        op_res[OP_SLL]    = sll_res;
        op_res[OP_SRL]    = srl_res;
        op_res[OP_SRA]    = sra_res;
        op_res[OP_SLT]    = {31'd0, lt_s};
        op_res[OP_SLTU]   = {31'd0, lt_u};
        op_res[OP_MUL]    = prod_uu[31:0];
        op_res[OP_MULH]   = mulh_res;
        op_res[OP_MULHSU] = mulhsu_res;
        op_res[OP_MULHU]  = mulhu_res;
        op_res[OP_DIV]    = div_zero ? 32'hFFFF_FFFF : quot_s;
        op_res[OP_DIVU]   = div_zero ? 32'hFFFF_FFFF : quot_u;
        op_res[OP_REM]    = div_zero ? op1 : rem_s;
        op_res[OP_REMU]   = div_zero ? op1 : rem_u;
        op_res[OP_EQ]     = {31'd0, eq};
        op_res[OP_NE]     = {31'd0, ~eq};
        op_res[OP_LT]     = {31'd0, lt_s};
        op_res[OP_GE]     = {31'd0, ~lt_s};
        op_res[OP_LTU]    = {31'd0, lt_u};
        op_res[OP_GEU]    = {31'd0, ~lt_u};
    end

    // AND-OR select; an illegal control word selects nothing and yields 0.
    logic [31:0] res_next;

    always_comb begin
        res_next = 32'd0;
        if (ctl_onehot) begin
            for (int i = 0; i < 24; i++) begin
                if (ctl[i]) begin
                    res_next = res_next | op_res[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= 32'd0;
        end else begin
            res <= res_next;
        end
    end

endmodule

// File: tb/tb_alu32_ff.sv
// tb/tb_alu32_ff.sv - scoreboard testbench for alu32_ff
module tb_alu32_ff;

    logic        clk;
    logic        rst;
    logic [23:0] ctl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    alu32_ff dut (
        .clk(clk),
        .rst(rst),
        .ctl(ctl),
        .op1(op1),
        .op2(op2),
        .res(res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4;
    localparam int SLL = 5, SRL = 6, SRA = 7, SLT = 8, SLTU = 9;
    localparam int MUL = 10, MULH = 11, MULHSU = 12, MULHU = 13;
    localparam int DIV = 14, DIVU = 15, REM = 16, REMU = 17;
    localparam int EQ = 18, NE = 19, LT = 20, GE = 21, LTU = 22, GEU = 23;

    function automatic logic [23:0] sel(int idx);
        logic [23:0] one;
        one = 24'd1;
        return one << idx;
    endfunction

    // Reference model: plain 64-bit integer arithmetic on the RISC-V rules.
    function automatic logic [31:0] model(bit r, logic [23:0] c, logic [31:0] a, logic [31:0] b);
        longint          sa;
        longint          sb_;
        longint          ua;
        longint          ub;
        longint          p;
        longint unsigned pu;
        int              op;
        int              sh;
        logic [31:0]     out;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        sh  = int'(b % 32);
        out = 32'd0;
        if (r) return 32'd0;
        if ($countones(c) != 1) return 32'd0;
        op = 0;
        for (int i = 0; i < 24; i++) if (c[i]) op = i;
        case (op)
            ADD:    out = 32'(ua + ub);
            SUB:    out = 32'(ua - ub);
            AND_:   out = a & b;
            OR_:    out = a | b;
            XOR_:   out = a ^ b;
            SLL:    out = 32'(ua * (64'd1 << sh));
            SRL:    out = 32'(ua / (64'd1 << sh));
            SRA:    begin p = sa >>> sh; out = p[31:0]; end
            SLT:    out = (sa < sb_) ? 32'd1 : 32'd0;
            SLTU:   out = (ua < ub) ? 32'd1 : 32'd0;
            MUL:    begin p = sa * sb_; out = p[31:0]; end
            MULH:   begin p = sa * sb_; out = p[63:32]; end
            MULHSU: begin p = sa * ub; out = p[63:32]; end
            MULHU:  begin pu = longint'(ua) * longint'(ub); out = pu[63:32]; end
            DIV:    begin if (b == 0) out = 32'hFFFF_FFFF; else begin p = sa / sb_; out = p[31:0]; end end
            DIVU:   begin if (b == 0) out = 32'hFFFF_FFFF; else begin p = ua / ub; out = p[31:0]; end end
            REM:    begin if (b == 0) out = a; else begin p = sa % sb_; out = p[31:0]; end end
            REMU:   begin if (b == 0) out = a; else begin p = ua % ub; out = p[31:0]; end end
            EQ:     out = (a == b) ? 32'd1 : 32'd0;
            NE:     out = (a != b) ? 32'd1 : 32'd0;
            LT:     out = (sa < sb_) ? 32'd1 : 32'd0;
            GE:     out = (sa >= sb_) ? 32'd1 : 32'd0;
            LTU:    out = (ua < ub) ? 32'd1 : 32'd0;
            GEU:    out = (ua >= ub) ? 32'd1 : 32'd0;
            default: out = 32'd0;
        endcase
        return out;
    endfunction

    task automatic issue(bit r, logic [23:0] c, logic [31:0] a, logic [31:0] b, string nm);
        exp_t e;
        @(negedge clk);
        rst = r;
        ctl = c;
        op1 = a;
        op2 = b;
        e.name = nm;
        e.val  = model(r, c, a, b);
        sb.push_back(e);
    endtask

    // Explicit expected values from the hand-worked cases.
    task automatic issue_exp(logic [23:0] c, logic [31:0] a, logic [31:0] b, logic [31:0] v, string nm);
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        ctl = c;
        op1 = a;
        op2 = b;
        e.name = nm;
        e.val  = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one registered result per edge, compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (res !== e.val) begin
                    errors++;
                    $display("FAIL %s: res=%08h expected=%08h", e.name, res, e.val);
                end
            end
        end
    end

    initial begin
        logic [23:0] c;
        int          k;
        int          k2;
        rst = 1'b1;
        ctl = 24'd0;
        op1 = 32'd0;
        op2 = 32'd0;

        issue(1'b1, sel(ADD), 32'd1, 32'd1, "reset");
        issue_exp(sel(ADD), 32'd1, 32'd1, 32'd2, "post_reset_add");
        issue(1'b1, sel(MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reset_priority");

        issue_exp(sel(ADD), 32'h0097423B, 32'h014872C1, 32'h01DFB4FC, "add");
        issue_exp(sel(SUB), 32'h0135721D, 32'h0086FC98, 32'h00AE7585, "sub");
        issue_exp(sel(MUL), 32'h8CBDA0FC, 32'h0012300F, 32'h1F03AEC4, "mul");

        issue_exp(sel(DIV),  32'h0AE02023, 32'h80000A12, 32'h0,        "div");
        issue_exp(sel(DIVU), 32'h0AE02023, 32'h80000A12, 32'h0,        "divu");
        issue_exp(sel(REM),  32'h0AE02023, 32'h80000A12, 32'h0AE02023, "rem");
        issue_exp(sel(REMU), 32'h0AE02023, 32'h80000A12, 32'h0AE02023, "remu");

        issue_exp(sel(DIV),  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
        issue_exp(sel(DIVU), 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");
        issue_exp(sel(REM),  32'h8765_4321, 32'd0, 32'h8765_4321, "rem_by_zero");
        issue_exp(sel(REMU), 32'h8765_4321, 32'd0, 32'h8765_4321, "remu_by_zero");
        issue_exp(sel(DIV),  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
        issue_exp(sel(REM),  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_overflow");
        issue_exp(sel(DIV),  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_trunc_neg");
        issue_exp(sel(REM),  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_sign_dividend");

        issue_exp(sel(MULH),   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
        issue_exp(sel(MULHU),  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        issue_exp(sel(MULHSU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        issue(1'b0, sel(MULH), 32'h8CBDA0FC, 32'h0012300F, "mulh_golden");

        issue_exp(sel(SRA),  32'h8000_0000, 32'h21, 32'hC000_0000, "sra_amount");
        issue_exp(sel(SLT),  32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
        issue_exp(sel(SLTU), 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
        issue_exp(sel(EQ),   32'd5, 32'd5, 32'd1, "eq");
        issue_exp(sel(GEU),  32'd0, 32'hFFFF_FFFF, 32'd0, "geu");
        issue_exp(24'h000003, 32'd7, 32'd3, 32'd0, "two_bits_set");
        issue_exp(24'h000000, 32'd7, 32'd3, 32'd0, "ctl_zero");

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 27);
            if (k < 24) begin
                c = sel(k);
            end else if (k == 24) begin
                c = 24'd0;
            end else begin
                k  = $urandom_range(0, 23);
                k2 = (k + $urandom_range(1, 23)) % 24;
                c  = sel(k) | sel(k2);
            end
            issue(($urandom_range(0, 49) == 0), c, rand_op(), rand_op(), "random");
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu32_ff.md
Name: alu32_ff

Overview:
- 32-bit integer ALU covering the RV32IM arithmetic/logic/multiply/divide operations plus branch compares, with a registered result.
- The operation is selected by a 24-bit one-hot control word; these are the ALU_CTL_* codes of the shared control-definition include.
- Sits in the execute stage; the result is valid one clock after the operands and control are presented.

Parameters:
- none (datapath fixed at 32 bits; control word fixed at 24 bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- ctl  input  24  one-hot operation select (bit map in Behaviour)
- op1  input  32  operand 1 (rs1)
- op2  input  32  operand 2 (rs2/imm)
- res  output  32  registered result

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: rst high at a rising edge sets res=0x00000000. Reset takes priority over any operation in that cycle.
- Latency: combinational compute from ctl/op1/op2; res is captured on every rising edge. Latency is 1 cycle and throughput is 1 op per cycle. There is no handshake or stall.
- Control bit map, one-hot (ctl[n]=1):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - 18 EQ, 19 NE, 20 LT, 21 GE, 22 LTU, 23 GEU
- ctl==0 or more than one bit set: res=0 on the next edge.
- ADD/SUB: modulo 2^32; carry and overflow are discarded.
- Logic ops: bitwise.
- Shifts: shift amount is op2[4:0]; upper op2 bits are ignored. SRA replicates op1[31].
- SLT/LT/GE: signed compare. SLTU/LTU/GEU: unsigned compare.
- Compare results (SLT, SLTU, EQ..GEU): 0x00000001 if true, else 0x00000000.
- Multiply, from the full 64-bit product:
  - MUL: low 32 bits (same for signed and unsigned).
  - MULH: high 32 bits of signed×signed.
  - MULHSU: high 32 bits of signed op1 × unsigned op2.
  - MULHU: high 32 bits of unsigned×unsigned.
- Divide: DIV/REM are signed and truncate toward zero; the remainder takes the sign of the dividend. DIVU/REMU are unsigned.
- Divide by zero (op2=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
- Signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Multiply and divide complete in the single cycle (combinational); there is no multi-cycle sequencer.
- Operand or ctl changes between edges do not affect res until the next rising edge.

Test Plan:
- Reset, and result latency:
  - Assert rst with ctl=ADD, op1=1, op2=1 -> res=0 after the edge.
  - Deassert rst -> res=2 exactly one edge later.
- Add, subtract, multiply low:
  - ADD 0x0097423B+0x014872C1 -> 0x01DFB4FC.
  - SUB 0x0135721D-0x0086FC98 -> 0x00AE7585.
  - MUL 0x8CBDA0FC*0x0012300F -> 0x1F03AEC4.
- Divide and remainder with op1=0x0AE02023, op2=0x80000A12:
  - DIV -> 0, DIVU -> 0, REM -> 0x0AE02023, REMU -> 0x0AE02023.
- Divide corner cases:
  - op2=0 -> DIV and DIVU give 0xFFFFFFFF; REM and REMU give op1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Multiply high:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - MULH of 0x8CBDA0FC*0x0012300F matches a signed 64-bit golden model.
- Shifts and compares:
  - SRA 0x80000000 by op2=0x21 -> 0xC0000000 (amount taken as 1).
  - SLT 0xFFFFFFFF<1 -> 1; SLTU on the same operands -> 0.
  - EQ 5,5 -> 1; GEU 0,0xFFFFFFFF -> 0.
  - ctl=0x000003 (two bits set) -> res=0.
